// File: rtl/tc_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tc_ram_pkg                                              |
// | Purpose  : Shared constants, FSM state encoding and lane helpers   |
// |            for the tc_lane_ram family.                             |
// | Contents : LANE_W      - width of one data lane (64 bits)          |
// |            tc_ram_state_e - clear-engine FSM state                 |
// |            lane_off()  - bit offset of a lane inside a packed word |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package tc_ram_pkg;

   localparam int LANE_W = 64;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } tc_ram_state_e;

   function automatic int unsigned lane_off(input int unsigned lane);
      return lane * LANE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tc_ram_clear_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tc_ram_clear_ctrl                                       |
// | Purpose  : Clear engine for tc_lane_ram. Walks the array one word  |
// |            per cycle after reset or on request and flags busy.     |
// | Ports    : clk      in   clock                                     |
// |            rst      in   synchronous active-high reset (restarts   |
// |                          the clear from word 0)                    |
// |            clear    in   clear request, honoured only in IDLE      |
// |            busy     out  high while the clear sweep runs           |
// |            clr_we   out  zero-write strobe for the array           |
// |            clr_addr out  word currently being zeroed               |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tc_ram_clear_ctrl
   import tc_ram_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   tc_ram_state_e     state;
   logic [ADDR_W-1:0] cnt;
   logic              last;

   assign last = (32'(cnt) == 32'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (last) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            ST_IDLE: begin
               if (clear) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= ST_CLEAR;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy     = (state == ST_CLEAR);
   assign clr_we   = busy;
   assign clr_addr = cnt;

endmodule
`default_nettype wire

// File: rtl/tc_lane_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tc_lane_ram                                             |
// | Purpose  : Lane-organised RAM: one masked write port, NUM_READ     |
// |            independent registered read ports, built-in clear.      |
// | Ports    : clk, rst          clock, synchronous active-high reset  |
// |            clear, busy       clear request / clear in progress     |
// |            we, waddr, wdata, wmask   write port, per-lane enables  |
// |            re, raddr         per-port read enable, packed addrs    |
// |            rdata, rvalid     packed read data, per-port valid      |
// | Config   : TC_RAM_BYPASS_EN - forward same-cycle written lanes to  |
// |            colliding reads (default: read-old)                     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tc_lane_ram
   import tc_ram_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int DEPTH    = 256,
   parameter int NUM_READ = 2,
   parameter int ADDR_W   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear,
   output logic                             busy,
   input  logic                             we,
   input  logic [ADDR_W-1:0]                waddr,
   input  logic [LANES*LANE_W-1:0]          wdata,
   input  logic [LANES-1:0]                 wmask,
   input  logic [NUM_READ-1:0]              re,
   input  logic [NUM_READ*ADDR_W-1:0]       raddr,
   output logic [NUM_READ*LANES*LANE_W-1:0] rdata,
   output logic [NUM_READ-1:0]              rvalid
);

   localparam int WORD_W = LANES * LANE_W;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_ok;

   tc_ram_clear_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_ctrl (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // User writes are accepted only in IDLE and only for in-range words;
   // everything else is silently discarded.
   assign wr_ok = we && !busy && (32'(waddr) < 32'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we) begin
            mem[clr_addr[IDX_W-1:0]] <= '0;
         end else if (wr_ok) begin
            for (int k = 0; k < LANES; k++) begin
               if (wmask[k]) begin
                  mem[waddr[IDX_W-1:0]][lane_off(k) +: LANE_W] <= wdata[lane_off(k) +: LANE_W];
               end
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              ra_ok;
      logic [WORD_W-1:0] old_word;
      logic [WORD_W-1:0] fwd_word;
      logic [WORD_W-1:0] rd_q;
      logic              v_q;

      assign ra       = raddr[p*ADDR_W +: ADDR_W];
      assign ra_ok    = (32'(ra) < 32'(DEPTH));
      // Out-of-range indices are never returned: ra_ok zeroes them below.
      assign old_word = mem[ra[IDX_W-1:0]];

`ifdef TC_RAM_BYPASS_EN
      // Merge the lanes being written this cycle over the stored word.
      always_comb begin
         fwd_word = old_word;
         if (wr_ok && (waddr == ra)) begin
            for (int k = 0; k < LANES; k++) begin
               if (wmask[k]) begin
                  fwd_word[lane_off(k) +: LANE_W] = wdata[lane_off(k) +: LANE_W];
               end
            end
         end
      end
`else
      assign fwd_word = old_word;
`endif

      // Data register is zeroed whenever valid is low so idle ports read 0.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q  <= 1'b0;
            rd_q <= '0;
         end else if (re[p] && !busy) begin
            v_q  <= 1'b1;
            rd_q <= ra_ok ? fwd_word : '0;
         end else begin
            v_q  <= 1'b0;
            rd_q <= '0;
         end
      end

      assign rdata[p*WORD_W +: WORD_W] = rd_q;
      assign rvalid[p]                 = v_q;
   end

endmodule
`default_nettype wire
